// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: fetch FSM states, instruction packet layout and fetch sizing constants
package fetch_ctrl_pkg;
  localparam int FETCH_N = 4;
  localparam int INST_BUFF_DEPTH = 8;
  localparam int FETCH_BLOCK_BYTES = FETCH_N * 4;
  typedef enum logic [1:0] {FETCH, WAIT, DRAIN} FETCH_STATE;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        valid;
    logic        illegal;
  } INST_PACKET;
  function automatic logic [31:0] block_base(input logic [31:0] a, input int n);
    return a & ~32'(n * 4 - 1);
  endfunction
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction
endpackage

// File: rtl/fetch_align.sv
// fetch_align: turns a returned I-cache block into oldest-first packets starting at the fetch offset
module fetch_align import fetch_ctrl_pkg::*; #(
  parameter int N = FETCH_N,
  parameter int CW = $clog2(N + 1)
) (
  input  logic              en,
  input  logic [31:0]       req_pc,
  input  logic [N*32-1:0]   rsp_data,
  output INST_PACKET [N-1:0] out_insts,
  output logic [CW-1:0]     count
);
  localparam int LW = $clog2(N);
  logic [LW-1:0] off;
  logic [31:0] base;
  assign off = req_pc[LW+1:2];
  assign base = block_base(req_pc, N);
  assign count = en ? CW'(N - int'(off)) : '0;
  // lane off+j lands in slot j; slots past the end of the block stay empty
  always_comb begin
    out_insts = '0;
    for (int j = 0; j < N; j++)
      if (en && int'(off) + j < N) begin
        out_insts[j].inst = rsp_data[32*(int'(off)+j) +: 32];
        out_insts[j].pc = base + 32'(4 * (int'(off) + j));
        out_insts[j].npc = base + 32'(4 * (int'(off) + j + 1));
        out_insts[j].valid = 1'b1;
      end
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch PC sequencing and I-cache request FSM; FETCH_CTRL_PERF_EN adds perf counters
module fetch_ctrl import fetch_ctrl_pkg::*; #(
  parameter int N = FETCH_N,
  parameter int DEPTH = INST_BUFF_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  input  logic [$clog2(DEPTH+1)-1:0] ib_open_entries,
  output logic                       icache_req_valid,
  output logic [31:0]                icache_req_addr,
  input  logic                       icache_req_ready,
  input  logic                       icache_rsp_valid,
  input  logic [N*32-1:0]            icache_rsp_data,
  output INST_PACKET [N-1:0]         out_insts,
  output logic [$clog2(DEPTH+1)-1:0] num_accept
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]                perf_fetched,
  output logic [31:0]                perf_stall_cycles,
  output logic [31:0]                perf_squashed
`endif
);
  localparam int AW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(N + 1);
  FETCH_STATE state, state_n;
  logic [31:0] pc, pc_n, req_pc;
  logic acc, hs;
  logic [CW-1:0] cnt;
  assign icache_req_addr = block_base(pc, N);
  assign num_accept = AW'(cnt);
  fetch_align #(.N(N), .CW(CW)) u_align (
    .en(acc),
    .req_pc(req_pc),
    .rsp_data(icache_rsp_data),
    .out_insts(out_insts),
    .count(cnt)
  );
  // next state and pc; a redirect always wins, and a response arriving while draining ends the drain even if a new redirect lands the same cycle
  always_comb begin
    state_n = state;
    pc_n = pc;
    icache_req_valid = 1'b0;
    acc = 1'b0;
    hs = 1'b0;
    case (state)
      FETCH: begin
        icache_req_valid = !reset && int'(ib_open_entries) >= N;
        hs = icache_req_valid && icache_req_ready;
        state_n = hs ? (redirect_valid ? DRAIN : WAIT) : FETCH;
      end
      WAIT: begin
        acc = !reset && icache_rsp_valid && !redirect_valid;
        state_n = icache_rsp_valid ? FETCH : redirect_valid ? DRAIN : WAIT;
        if (acc) pc_n = block_base(req_pc, N) + 32'(N * 4);
      end
      DRAIN: state_n = icache_rsp_valid ? FETCH : DRAIN;
      default: state_n = FETCH;
    endcase
    if (redirect_valid) pc_n = redirect_pc;
  end
  // state, fetch pc, and the pc of the request currently in flight
  always_ff @(posedge clock)
    if (reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      state <= state_n;
      pc <= pc_n;
      if (hs) req_pc <= pc;
    end
`ifdef FETCH_CTRL_PERF_EN
  // saturating counters for delivered instructions, buffer-full stalls and dropped responses
  always_ff @(posedge clock)
    if (reset) begin
      perf_fetched <= '0;
      perf_stall_cycles <= '0;
      perf_squashed <= '0;
    end else begin
      perf_fetched <= sat_add(perf_fetched, 32'(num_accept));
      perf_stall_cycles <= sat_add(perf_stall_cycles, 32'(state == FETCH && int'(ib_open_entries) < N));
      perf_squashed <= sat_add(perf_squashed, 32'(icache_rsp_valid && !acc));
    end
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and random fetch traffic checked by a scoreboard against a request/response model
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;
  typedef INST_PACKET [3:0] pk_t;
  logic clock = 0;
  logic reset = 1;
  logic redirect_valid = 0;
  logic [31:0] redirect_pc = '0;
  logic [3:0] ib_open_entries = '0;
  logic icache_req_valid;
  logic [31:0] icache_req_addr;
  logic icache_req_ready = 0;
  logic icache_rsp_valid = 0;
  logic [127:0] icache_rsp_data = '0;
  pk_t out_insts;
  logic [3:0] num_accept;
  int checks = 0;
  int errors = 0;
  logic [32:0] req_q[$];
  int cnt_q[$];
  pk_t pk_q[$];
  logic [31:0] m_pc = '0, m_req_pc = '0;
  bit m_busy = 0, m_stale = 0;
  int m_lat = 0;
  fetch_ctrl #(.N(4), .DEPTH(8), .RESET_PC(32'h0)) dut (
    .clock(clock),
    .reset(reset),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .ib_open_entries(ib_open_entries),
    .icache_req_valid(icache_req_valid),
    .icache_req_addr(icache_req_addr),
    .icache_req_ready(icache_req_ready),
    .icache_rsp_valid(icache_rsp_valid),
    .icache_rsp_data(icache_rsp_data),
    .out_insts(out_insts),
    .num_accept(num_accept)
  );
  always #5 clock = ~clock;
  task automatic chk(input string n, input logic [511:0] a, input logic [511:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  // one cycle of stimulus; the model predicts the request and any response outcome, then advances
  task automatic cyc(input logic r, input int open, input logic rdy, input logic rd, input logic [31:0] rpc, input logic rs);
    logic ev, acc, rsv;
    logic [31:0] old, blk;
    int off, cnt;
    pk_t pk;
    logic [127:0] d;
    @(negedge clock);
    rsv = rs && m_busy && !r;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    reset = r;
    ib_open_entries = 4'(open);
    icache_req_ready = rdy;
    redirect_valid = rd;
    redirect_pc = rpc;
    icache_rsp_valid = rsv;
    icache_rsp_data = d;
    ev = !r && !m_busy && open >= 4;
    req_q.push_back({ev, m_pc & 32'hFFFF_FFF0});
    acc = rsv && !m_stale && !rd;
    off = int'(m_req_pc[3:2]);
    blk = m_req_pc & 32'hFFFF_FFF0;
    if (rsv) begin
      pk = '0;
      cnt = acc ? 4 - off : 0;
      if (acc)
        for (int i = off; i < 4; i++) begin
          pk[i-off].inst = d[32*i +: 32];
          pk[i-off].pc = blk + 32'(4 * i);
          pk[i-off].npc = blk + 32'(4 * i + 4);
          pk[i-off].valid = 1'b1;
        end
      cnt_q.push_back(cnt);
      pk_q.push_back(pk);
    end
    if (r) begin
      m_pc = '0;
      m_busy = 0;
      m_stale = 0;
      m_lat = 0;
    end else begin
      old = m_pc;
      if (rd) m_pc = rpc;
      else if (acc) m_pc = blk + 32'd16;
      if (rsv) begin
        m_busy = 0;
        m_stale = 0;
      end else if (rd && m_busy) m_stale = 1;
      if (ev && rdy) begin
        m_busy = 1;
        m_stale = rd;
        m_req_pc = old;
        m_lat = $urandom_range(0, 3);
      end else if (m_lat > 0) m_lat--;
    end
  endtask
  // monitor: compares the request every cycle and the buffer write whenever a response is presented
  initial begin : mon
    logic [32:0] r;
    int c;
    pk_t p;
    forever begin
      @(negedge clock);
      #2;
      if (req_q.size() > 0) begin
        r = req_q.pop_front();
        chk("req_valid", 512'(icache_req_valid), 512'(r[32]));
        if (r[32]) chk("req_addr", 512'(icache_req_addr), 512'(r[31:0]));
        if (icache_rsp_valid) begin
          if (cnt_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_queue: response seen with no expectation queued");
          end else begin
            c = cnt_q.pop_front();
            p = pk_q.pop_front();
            chk("num_accept", 512'(num_accept), 512'(c));
            chk("out_insts", 512'(out_insts), 512'(p));
          end
        end else begin
          chk("idle_num_accept", 512'(num_accept), 512'(0));
          chk("idle_out_insts", 512'(out_insts), 512'(0));
        end
      end
    end
  end
  initial begin
    logic [31:0] rpc;
    cyc(1, 8, 1, 0, 0, 0);
    cyc(1, 8, 1, 0, 0, 0);
    cyc(0, 8, 1, 0, 0, 0);
    cyc(0, 8, 1, 0, 0, 1);
    cyc(0, 8, 0, 0, 0, 0);
    cyc(0, 8, 0, 1, 32'h108, 0);
    cyc(0, 8, 1, 0, 0, 0);
    cyc(0, 8, 1, 0, 0, 1);
    repeat (3) cyc(0, 3, 1, 0, 0, 0);
    cyc(0, 4, 1, 0, 0, 0);
    cyc(0, 8, 1, 0, 0, 1);
    cyc(0, 8, 1, 0, 0, 0);
    cyc(0, 8, 0, 1, 32'h200, 0);
    cyc(0, 8, 1, 0, 0, 1);
    cyc(0, 8, 1, 0, 0, 0);
    cyc(0, 8, 1, 0, 0, 1);
    cyc(0, 8, 1, 0, 0, 0);
    cyc(0, 8, 1, 1, 32'h300, 1);
    cyc(0, 8, 1, 0, 0, 0);
    cyc(0, 8, 1, 0, 0, 1);
    cyc(0, 8, 1, 0, 0, 0);
    cyc(1, 8, 1, 0, 0, 0);
    cyc(0, 8, 1, 0, 0, 0);
    cyc(0, 8, 1, 0, 0, 1);
    cyc(0, 8, 1, 1, 32'hFFFF_FFF8, 0);
    cyc(0, 8, 1, 0, 0, 0);
    cyc(0, 8, 1, 0, 0, 1);
    cyc(0, 8, 1, 0, 0, 0);
    cyc(0, 8, 1, 0, 0, 1);
    for (int k = 0; k < 3000; k++) begin
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 8), $urandom_range(0, 1) == 1,
          $urandom_range(0, 7) == 0, rpc, m_lat == 0);
    end
    repeat (2) @(negedge clock);
    #3;
    checks++;
    if (req_q.size() != 0 || cnt_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queues: req %0d rsp %0d left, expected 0", req_q.size(), cnt_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
